// File: rtl/temp_ctrl_pkg.sv
// Shared types and constants for the temperature acquisition path.
package temp_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Selects one of the three capture slots (a, b, c).
  typedef logic [1:0] slot_idx_t;

  // The bit-wise majority voter downstream needs at least this many bits.
  localparam int MIN_BIT_WIDTH = 4;

  // Bits needed to hold max_value in a down counter; never less than one.
  function automatic int counter_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/triple_sample_collector_if.sv
// Bundle between the acquisition sequencer, its controller and the sensor
// front-end. The master modport is the sequencer itself.
interface triple_sample_collector_if #(
  parameter int BIT_WIDTH = 4
);
  logic                 start;
  logic                 busy;
  logic                 req;
  logic                 ack;
  logic [BIT_WIDTH-1:0] ack_data;
  logic [BIT_WIDTH-1:0] sample_a;
  logic [BIT_WIDTH-1:0] sample_b;
  logic [BIT_WIDTH-1:0] sample_c;
  logic                 valid;
  logic                 timeout_err;

  modport master (
    input  start, ack, ack_data,
    output busy, req, sample_a, sample_b, sample_c, valid, timeout_err
  );

  modport slave (
    output start, ack, ack_data,
    input  busy, req, sample_a, sample_b, sample_c, valid, timeout_err
  );
endinterface

// File: rtl/cycle_timer.sv
// Loadable down counter that stops at zero; tc flags the terminal count.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             tc
);
  logic [WIDTH-1:0] count_q;

  // Load has priority over counting; counting saturates at zero.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign tc = (count_q == '0);
endmodule

// File: rtl/triple_sample_collector.sv
// Requests three sensor readings over req/ack with a programmable gap and
// presents them together to the majority voter with a one-cycle valid.
module triple_sample_collector
  import temp_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH      = 4,
  parameter int SAMPLE_GAP     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                        clk,
  input logic                        rst,
  triple_sample_collector_if.master  bus
);
  // A timer loaded with N-1 reaches terminal count on its N-th cycle.
  localparam int GAP_LOAD = (SAMPLE_GAP == 0) ? 0 : SAMPLE_GAP - 1;
  localparam int TMO_LOAD = TIMEOUT_CYCLES - 1;
  localparam int GW       = counter_width(GAP_LOAD);
  localparam int TW       = counter_width(TMO_LOAD);

  state_t               state_q, state_d;
  slot_idx_t            idx_q, idx_d;
  logic                 req_q, req_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 terr_q, terr_d;
  logic [BIT_WIDTH-1:0] slot_a_q, slot_a_d;
  logic [BIT_WIDTH-1:0] slot_b_q, slot_b_d;
  logic [BIT_WIDTH-1:0] slot_c_q, slot_c_d;

  logic gap_load, gap_en, gap_tc;
  logic tmo_load, tmo_en, tmo_tc;

  cycle_timer #(.WIDTH(GW)) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (gap_load),
    .load_value (GW'(GAP_LOAD)),
    .en         (gap_en),
    .tc         (gap_tc)
  );

  cycle_timer #(.WIDTH(TW)) u_timeout_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmo_load),
    .load_value (TW'(TMO_LOAD)),
    .en         (tmo_en),
    .tc         (tmo_tc)
  );

  // Next-state, slot capture and timer control; outputs are decoded from
  // the next state so they leave the block straight from flops.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    idx_d    = idx_q;
    terr_d   = terr_q;
    slot_a_d = slot_a_q;
    slot_b_d = slot_b_q;
    slot_c_d = slot_c_q;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    tmo_load = 1'b0;
    tmo_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = REQ;
          idx_d    = '0;
          terr_d   = 1'b0;
          slot_a_d = '0;
          slot_b_d = '0;
          slot_c_d = '0;
          tmo_load = 1'b1;
        end
      end
      REQ: begin
        if (bus.ack) begin
          case (idx_q)
            2'd0:    slot_a_d = bus.ack_data;
            2'd1:    slot_b_d = bus.ack_data;
            default: slot_c_d = bus.ack_data;
          endcase
          if (idx_q == 2'd2) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 2'd1;
            if (SAMPLE_GAP == 0) begin
              tmo_load = 1'b1;
            end else begin
              state_d  = GAP;
              gap_load = 1'b1;
            end
          end
        end else if (tmo_tc) begin
          // Ack in this last allowed cycle was handled above, so ack wins.
          state_d = IDLE;
          terr_d  = 1'b1;
        end else begin
          tmo_en = 1'b1;
        end
      end
      GAP: begin
        if (gap_tc) begin
          state_d  = REQ;
          tmo_load = 1'b1;
        end else begin
          gap_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_d   = (state_d == REQ);
    busy_d  = (state_d == REQ) || (state_d == GAP);
    valid_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
      // NOTE: the slots are data registers but still reset, because they drive the voter directly.
      slot_a_q <= '0;
      slot_b_q <= '0;
      slot_c_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
      slot_a_q <= slot_a_d;
      slot_b_q <= slot_b_d;
      slot_c_q <= slot_c_d;
    end
  end

  assign bus.req         = req_q;
  assign bus.busy        = busy_q;
  assign bus.valid       = valid_q;
  assign bus.timeout_err = terr_q;
  assign bus.sample_a    = slot_a_q;
  assign bus.sample_b    = slot_b_q;
  assign bus.sample_c    = slot_c_q;
endmodule

// File: tb/tb_triple_sample_collector.sv
// Directed bench for triple_sample_collector: one DUT with a 4-cycle gap and
// an 8-cycle timeout, one with zero gap.
module tb_triple_sample_collector;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  triple_sample_collector_if #(.BIT_WIDTH(BW)) if4 ();
  triple_sample_collector_if #(.BIT_WIDTH(BW)) if0 ();

  triple_sample_collector #(.BIT_WIDTH(BW), .SAMPLE_GAP(4), .TIMEOUT_CYCLES(8)) dut_g4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  triple_sample_collector #(.BIT_WIDTH(BW), .SAMPLE_GAP(0), .TIMEOUT_CYCLES(255)) dut_g0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  // Advance into the next cycle; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sequence on the gap-4 DUT. The start pulse goes out in cycle t;
  // the loop then covers cycles t+1 .. t+n_cycles. dly_k is how many req
  // cycles request k waits before its ack (-1 = never). data holds the three
  // readings, first in the top nibble. start2_at re-pulses start at that
  // offset; spurious drives ack=F while busy with req low.
  task automatic run4(input int n_cycles, input int dly0, input int dly1, input int dly2,
                      input logic [11:0] data, input int start2_at, input bit spurious,
                      output int valid_at, output int n_valid, output int terr_at,
                      output int req_cycles);
    int dly [3];
    int ack_idx;
    int wait_cnt;
    dly      = '{dly0, dly1, dly2};
    ack_idx  = 0;
    wait_cnt = 0;
    valid_at = -1;
    n_valid  = 0;
    terr_at  = -1;
    req_cycles = 0;
    if4.start = 1'b1;
    tick();
    for (int c = 1; c <= n_cycles; c++) begin
      if (if4.valid) begin
        n_valid++;
        if (valid_at < 0) valid_at = c;
      end
      if (if4.timeout_err && terr_at < 0) terr_at = c;
      if (if4.req) req_cycles++;
      if4.start    = (c == start2_at);
      if4.ack      = 1'b0;
      if4.ack_data = '0;
      if (if4.req && ack_idx < 3 && dly[ack_idx] >= 0) begin
        if (wait_cnt == dly[ack_idx]) begin
          if4.ack      = 1'b1;
          if4.ack_data = data[11-4*ack_idx -: 4];
          ack_idx++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else if (!if4.req && if4.busy && spurious) begin
        if4.ack      = 1'b1;
        if4.ack_data = 4'hF;
      end
      tick();
    end
    if4.start    = 1'b0;
    if4.ack      = 1'b0;
    if4.ack_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({if4.busy, if4.req, if4.valid, if4.timeout_err, if4.sample_a, if4.sample_b, if4.sample_c} !== '0) begin
      miscompares++;
      $display("FAIL reset_g4: got busy/req/valid/terr=%b%b%b%b slots=%h/%h/%h, expected all 0",
               if4.busy, if4.req, if4.valid, if4.timeout_err, if4.sample_a, if4.sample_b, if4.sample_c);
    end
    vectors++;
    if ({if0.busy, if0.req, if0.valid, if0.timeout_err, if0.sample_a, if0.sample_b, if0.sample_c} !== '0) begin
      miscompares++;
      $display("FAIL reset_g0: got busy/req/valid/terr=%b%b%b%b slots=%h/%h/%h, expected all 0",
               if0.busy, if0.req, if0.valid, if0.timeout_err, if0.sample_a, if0.sample_b, if0.sample_c);
    end
  endtask

  task automatic test_nominal();
    int va, nv, ta, rc;
    // Immediate acks, G=4: valid at t+4+2*4 = t+12, three req cycles in total.
    run4(14, 0, 0, 0, 12'hA3A, -1, 1'b0, va, nv, ta, rc);
    vectors++;
    if (va !== 12 || nv !== 1) begin
      miscompares++;
      $display("FAIL nominal_valid: got cycle %0d count %0d, expected cycle 12 count 1", va, nv);
    end
    vectors++;
    if ({if4.sample_a, if4.sample_b, if4.sample_c} !== 12'hA3A) begin
      miscompares++;
      $display("FAIL nominal_slots: got %h/%h/%h, expected a/3/a", if4.sample_a, if4.sample_b, if4.sample_c);
    end
    vectors++;
    if (rc !== 3 || ta !== -1 || if4.busy !== 1'b0 || if4.timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_flags: got req_cycles %0d terr_at %0d busy %b terr %b, expected 3 -1 0 0",
               rc, ta, if4.busy, if4.timeout_err);
    end
  endtask

  task automatic test_zero_gap();
    logic [11:0] vals;
    logic [5:0]  req_pat;
    int          n;
    int          va;
    vals    = 12'h5C9;
    req_pat = '0;
    n       = 0;
    va      = -1;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (if0.valid && va < 0) va = c;
      req_pat[c-1] = if0.req;
      if (if0.req && n < 3) begin
        if0.ack      = 1'b1;
        if0.ack_data = vals[11-4*n -: 4];
        n++;
      end else begin
        if0.ack      = 1'b0;
        if0.ack_data = '0;
      end
      tick();
    end
    if0.ack = 1'b0;
    vectors++;
    if (req_pat !== 6'b000111) begin
      miscompares++;
      $display("FAIL zero_gap_req: got pattern %b, expected 000111", req_pat);
    end
    vectors++;
    if (va !== 4) begin
      miscompares++;
      $display("FAIL zero_gap_valid: got cycle %0d, expected 4", va);
    end
    vectors++;
    if ({if0.sample_a, if0.sample_b, if0.sample_c} !== 12'h5C9) begin
      miscompares++;
      $display("FAIL zero_gap_slots: got %h/%h/%h, expected 5/c/9", if0.sample_a, if0.sample_b, if0.sample_c);
    end
  endtask

  task automatic test_timeout();
    int va, nv, ta, rc;
    // Second req rises at t+6, held t+6..t+13 (8 cycles), error visible at t+14.
    run4(20, 0, -1, -1, 12'h600, -1, 1'b0, va, nv, ta, rc);
    vectors++;
    if (ta !== 14 || rc !== 9) begin
      miscompares++;
      $display("FAIL timeout_timing: got terr_at %0d req_cycles %0d, expected 14 9", ta, rc);
    end
    vectors++;
    if (nv !== 0 || if4.busy !== 1'b0 || if4.timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_state: got valids %0d busy %b terr %b, expected 0 0 1", nv, if4.busy, if4.timeout_err);
    end
    vectors++;
    if (if4.sample_a !== 4'h6 || if4.sample_b !== 4'h0) begin
      miscompares++;
      $display("FAIL timeout_slots: got a=%h b=%h, expected a=6 b=0", if4.sample_a, if4.sample_b);
    end
    // Next start must clear the sticky flag on its first busy cycle.
    run4(14, 0, 0, 0, 12'h123, -1, 1'b0, va, nv, ta, rc);
    vectors++;
    if (ta !== -1 || va !== 12 || if4.timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: got terr_at %0d valid_at %0d terr %b, expected -1 12 0", ta, va, if4.timeout_err);
    end
  endtask

  task automatic test_boundary();
    int va, nv, ta, rc;
    // Ack in the 8th req cycle (t+8), then immediate acks at t+13, t+18; DONE t+19.
    run4(22, 7, 0, 0, 12'h947, -1, 1'b1, va, nv, ta, rc);
    vectors++;
    if (ta !== -1 || va !== 19 || rc !== 10) begin
      miscompares++;
      $display("FAIL boundary_ack: got terr_at %0d valid_at %0d req_cycles %0d, expected -1 19 10", ta, va, rc);
    end
    vectors++;
    if ({if4.sample_a, if4.sample_b, if4.sample_c} !== 12'h947) begin
      miscompares++;
      $display("FAIL gap_spurious_ack: got %h/%h/%h, expected 9/4/7", if4.sample_a, if4.sample_b, if4.sample_c);
    end
  endtask

  task automatic test_start_ignored();
    int va, nv, ta, rc;
    run4(14, 0, 0, 0, 12'h3C3, 3, 1'b0, va, nv, ta, rc);
    vectors++;
    if (va !== 12 || rc !== 3 || {if4.sample_a, if4.sample_b, if4.sample_c} !== 12'h3C3) begin
      miscompares++;
      $display("FAIL start_while_busy: got valid_at %0d req_cycles %0d slots %h/%h/%h, expected 12 3 3/c/3",
               va, rc, if4.sample_a, if4.sample_b, if4.sample_c);
    end
    run4(16, 0, 0, 0, 12'h852, 12, 1'b0, va, nv, ta, rc);
    vectors++;
    if (va !== 12 || rc !== 3 || if4.busy !== 1'b0 || if4.req !== 1'b0) begin
      miscompares++;
      $display("FAIL start_during_done: got valid_at %0d req_cycles %0d busy %b req %b, expected 12 3 0 0",
               va, rc, if4.busy, if4.req);
    end
  endtask

  task automatic test_reset_midway();
    int va, nv, ta, rc;
    if4.start = 1'b1;
    tick();
    if4.start    = 1'b0;
    if4.ack      = 1'b1;
    if4.ack_data = 4'hB;
    tick();
    if4.ack      = 1'b0;
    if4.ack_data = '0;
    for (int c = 2; c < 8; c++) tick();
    vectors++;
    if (if4.req !== 1'b1 || if4.sample_a !== 4'hB) begin
      miscompares++;
      $display("FAIL midway_pre_reset: got req %b a=%h, expected 1 b", if4.req, if4.sample_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({if4.busy, if4.req, if4.valid, if4.timeout_err, if4.sample_a, if4.sample_b, if4.sample_c} !== '0) begin
      miscompares++;
      $display("FAIL midway_reset: got busy/req/valid/terr=%b%b%b%b slots=%h/%h/%h, expected all 0",
               if4.busy, if4.req, if4.valid, if4.timeout_err, if4.sample_a, if4.sample_b, if4.sample_c);
    end
    run4(14, 0, 0, 0, 12'hC5C, -1, 1'b0, va, nv, ta, rc);
    vectors++;
    if (va !== 12 || nv !== 1 || {if4.sample_a, if4.sample_b, if4.sample_c} !== 12'hC5C) begin
      miscompares++;
      $display("FAIL after_reset_run: got valid_at %0d count %0d slots %h/%h/%h, expected 12 1 c/5/c",
               va, nv, if4.sample_a, if4.sample_b, if4.sample_c);
    end
  endtask

  initial begin
    rst          = 1'b1;
    if4.start    = 1'b0;
    if4.ack      = 1'b0;
    if4.ack_data = '0;
    if0.start    = 1'b0;
    if0.ack      = 1'b0;
    if0.ack_data = '0;
    test_reset();
    test_nominal();
    test_zero_gap();
    test_timeout();
    test_boundary();
    test_start_ignored();
    test_reset_midway();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stalled simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, expected completion");
    $fatal(1, "simulation stalled");
  end
endmodule

// File: doc/triple_sample_collector.md
# triple_sample_collector

Acquisition sequencer that drives the producer side of the triple-redundant voting path. On a start pulse it requests three consecutive readings from the temperature sensor front-end over a req/ack handshake, with a programmable gap between requests. It captures the readings into three slots and presents them together, with a one-cycle valid strobe, to the bit-wise majority voter. A missing acknowledge aborts the sequence and raises a sticky timeout flag.

## Interface
- BIT_WIDTH, 4: width of each sensor reading and of each output slot; minimum 4 (voter requirement).
- SAMPLE_GAP, 4: idle cycles between an accepted ack and the next request; 0 allowed.
- TIMEOUT_CYCLES, 255: maximum cycles req stays high without ack; minimum 1.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse begins a sequence; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the cycle valid or timeout_err asserts.
- req  out  1  request to sensor front-end; held high until ack or timeout.
- ack  in  1  sensor acknowledges; qualifies ack_data; only sampled while req=1.
- ack_data  in  BIT_WIDTH  reading delivered with ack.
- sample_a / sample_b / sample_c  out  BIT_WIDTH each  first/second/third captured reading; held until the next accepted start.
- valid  out  1  one-cycle pulse; all three slots are fresh.
- timeout_err  out  1  sticky; set on timeout, cleared by the next accepted start or by rst.

## Operation
- States: IDLE, REQ, GAP, DONE.
- IDLE: start=1 -> REQ, slot index idx=0, clear timeout_err, clear all three slots to 0.
- REQ: req=1. ack=1 -> capture ack_data into slot idx. Then: idx=2 -> DONE; else idx+1 -> GAP, or directly back to REQ if SAMPLE_GAP=0.
- REQ without ack: the timeout counter increments each cycle. After TIMEOUT_CYCLES consecutive req cycles without ack -> IDLE with timeout_err=1. valid does not pulse. Partially captured slots keep their values.
- GAP: req=0; count SAMPLE_GAP cycles, then -> REQ. The timeout counter resets on every REQ entry.
- DONE: valid=1 for exactly one cycle -> IDLE.
- ack while req=0 is ignored. start while busy=1 is ignored. start in the DONE cycle is ignored.
- ack in the final allowed timeout cycle is accepted; ack wins over timeout.
- rst at any point: state IDLE, counters 0, all outputs 0, including the slots.

## Timing
- Reset value: busy, req, valid, timeout_err = 0; sample_a/b/c = 0.
- All outputs are registered; no combinational path from any input to any output.
- start sampled at cycle t -> busy and req high at t+1.
- ack sampled high at cycle n -> req low at n+1 and the slot updates at n+1.
- With SAMPLE_GAP=G: the next req rises at n+1+G. For G=0, req stays high continuously across requests.
- Minimum latency, with ack on every first req cycle: valid at t+4+2G. busy falls in the same cycle valid rises.
- Timeout: req high for exactly TIMEOUT_CYCLES cycles. timeout_err=1 and req=0 in the following cycle.

## Structure
- Shared package temp_ctrl_pkg:
  - state enum (IDLE, REQ, GAP, DONE);
  - slot index type (2 bits);
  - localparam for minimum BIT_WIDTH = 4.
- One sub-module, cycle_timer: a loadable counter with a terminal-count flag. Instantiated twice, once for the gap and once for the timeout.
- The majority voter is instantiated by the parent, not inside this block.

## Test plan
- Nominal: BIT_WIDTH=4, G=4. start; ack with 4'hA, 4'h3, 4'hA on first req cycles -> slots A/3/A, valid at t+12, busy low, timeout_err=0.
- Zero gap: G=0, acks immediate -> req high for 3 consecutive cycles, valid at t+4, slots match ack_data order.
- Timeout: TIMEOUT_CYCLES=8, no ack on the second request -> req high exactly 8 cycles, then timeout_err=1, busy=0, no valid, sample_a kept. Next start clears timeout_err.
- Boundary: ack in the 8th req cycle with TIMEOUT_CYCLES=8 -> accepted, no timeout_err. Spurious ack during GAP -> no capture.
- start while busy and during DONE -> ignored, no sequence restart.
- rst asserted while waiting for the second ack -> next cycle all outputs 0 and state IDLE. A fresh start then completes normally.
